// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch path and the later pipeline stages.
// A fetch entry pairs an instruction word with the PC it was fetched from.
package rv32_pkg;
  localparam int XLEN        = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries with flush; the head reads as zero when empty.
// Flush dominates push and pop in the same cycle.
module fetch_buffer
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output fetch_entry_t           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited memory requests and
// queues in-order responses for decode; redirects flush and discard stale work.
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   out_after_rsp;
  logic [CW:0]     in_use;
  logic            req_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            empty;
  logic            unused_ok;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  assign target_pc = {redirect_pc[31:2], 2'b00};
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Buffered plus in-flight words may never exceed the buffer size.
  assign in_use         = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error; ignore it rather than underflow.
  assign rsp_ok        = imem_rsp_valid && (outstanding != '0);
  assign out_after_rsp = outstanding - CW'(rsp_ok);
  assign push          = rsp_ok && !redirect_valid && (discard == '0);
  assign pop           = if_valid && if_ready && !redirect_valid;

  assign push_data.pc    = rsp_pc;
  assign push_data.instr = imem_rsp_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= target_pc;
      rsp_pc      <= target_pc;
      outstanding <= out_after_rsp;
      discard     <= out_after_rsp;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
      outstanding <= out_after_rsp + CW'(req_fire);
      if (rsp_ok) begin
        if (discard != '0) discard <= discard - CW'(1);
        else               rsp_pc  <= rsp_pc + 32'(INSTR_BYTES);
      end
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .empty     (empty),
    .head      (head)
  );

  assign if_valid = !empty;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;
endmodule
